// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S data path: decoded instruction set, opcodes and ALU operations.
package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE,
    I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SHL, I_SHR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO,
    I_CALL, I_RET, I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_XOR    = 8'hA5;
  localparam logic [7:0] OP_SHL    = 8'hA6;
  localparam logic [7:0] OP_SHR    = 8'hA7;
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BOV    = 8'h05;
  localparam logic [7:0] OP_BNOV   = 8'h06;
  localparam logic [7:0] OP_BNNEG  = 8'h0A;
  localparam logic [7:0] OP_BNZERO = 8'h0B;
  localparam logic [7:0] OP_CALL   = 8'h0C;
  localparam logic [7:0] OP_RET    = 8'h0D;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef enum logic [2:0] {
    ALU_OR   = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_SHR  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_t;

endpackage

// File: rtl/ks_return_stack.sv
// Return-address LIFO for CALL/RET; pointer runs 0..DEPTH, misuse sets a sticky error.
module ks_return_stack #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     ptr_r;
  logic              err_r;
  logic [IW-1:0]     top_idx_s;

  assign empty     = (ptr_r == '0);
  assign full      = (ptr_r == PW'(DEPTH));
  assign top_idx_s = IW'(ptr_r - PW'(1));
  assign top       = empty ? '0 : mem_r[top_idx_s];
  assign err       = err_r;

  // Pointer, storage and sticky error; simultaneous push+pop is a misuse with no stack change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
      err_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push && pop) begin
      err_r <= 1'b1;
    end else if (pop) begin
      if (empty) err_r <= 1'b1;
      else       ptr_r <= ptr_r - PW'(1);
    end else if (push) begin
      if (full) begin
        err_r <= 1'b1;
      end else begin
        mem_r[IW'(ptr_r)] <= din;
        ptr_r             <= ptr_r + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ks_data_path_p.sv
// K&S data path: PC, IR, register file, ALU, flags and return stack, steered by the control unit.
module ks_data_path_p
  import k_and_s_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 5,
  parameter int NUM_REGS    = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [2:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic                    stack_push,
  input  logic                    stack_pop,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic                    stack_full,
  output logic                    stack_empty,
  output logic                    stack_err,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  localparam int REG_AW = $clog2(NUM_REGS);

  logic [ADDR_W-1:0] pc_r, pc_next_s, pc_inc_s, addr_s, st_top_s;
  logic [DATA_W-1:0] ir_r, bus_a_s, bus_b_s, bus_c_s, bop_s, alu_res_s;
  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [REG_AW-1:0] a_s, b_s, c_s;
  logic [7:0]        opcode_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] low_s;
  logic              sub_s, un_s, sg_s;
  alu_op_t           alu_op_s;
  decoded_instruction_type dec_s;
  logic              unused_s;

  assign opcode_s = ir_r[DATA_W-1 -: 8];
  assign unused_s = ^ir_r;

  // Opcode decode; fields not used by an instruction stay 0.
  always_comb begin
    dec_s  = I_NOP;
    a_s    = '0;
    b_s    = '0;
    c_s    = '0;
    addr_s = '0;
    case (opcode_s)
      OP_LOAD:   begin dec_s = I_LOAD;  c_s = ir_r[ADDR_W+REG_AW-1:ADDR_W]; addr_s = ir_r[ADDR_W-1:0]; end
      OP_STORE:  begin dec_s = I_STORE; a_s = ir_r[ADDR_W+REG_AW-1:ADDR_W]; addr_s = ir_r[ADDR_W-1:0]; end
      OP_MOVE:   begin dec_s = I_MOVE;  c_s = ir_r[2*REG_AW-1:REG_AW]; a_s = ir_r[REG_AW-1:0]; b_s = ir_r[REG_AW-1:0]; end
      OP_ADD:    begin dec_s = I_ADD; {c_s, b_s, a_s} = ir_r[3*REG_AW-1:0]; end
      OP_SUB:    begin dec_s = I_SUB; {c_s, b_s, a_s} = ir_r[3*REG_AW-1:0]; end
      OP_AND:    begin dec_s = I_AND; {c_s, b_s, a_s} = ir_r[3*REG_AW-1:0]; end
      OP_OR:     begin dec_s = I_OR;  {c_s, b_s, a_s} = ir_r[3*REG_AW-1:0]; end
      OP_XOR:    begin dec_s = I_XOR; {c_s, b_s, a_s} = ir_r[3*REG_AW-1:0]; end
      OP_SHL:    begin dec_s = I_SHL; {c_s, b_s, a_s} = ir_r[3*REG_AW-1:0]; end
      OP_SHR:    begin dec_s = I_SHR; {c_s, b_s, a_s} = ir_r[3*REG_AW-1:0]; end
      OP_BRANCH: begin dec_s = I_BRANCH; addr_s = ir_r[ADDR_W-1:0]; end
      OP_BZERO:  begin dec_s = I_BZERO;  addr_s = ir_r[ADDR_W-1:0]; end
      OP_BNEG:   begin dec_s = I_BNEG;   addr_s = ir_r[ADDR_W-1:0]; end
      OP_BOV:    begin dec_s = I_BOV;    addr_s = ir_r[ADDR_W-1:0]; end
      OP_BNOV:   begin dec_s = I_BNOV;   addr_s = ir_r[ADDR_W-1:0]; end
      OP_BNNEG:  begin dec_s = I_BNNEG;  addr_s = ir_r[ADDR_W-1:0]; end
      OP_BNZERO: begin dec_s = I_BNZERO; addr_s = ir_r[ADDR_W-1:0]; end
      OP_CALL:   begin dec_s = I_CALL;   addr_s = ir_r[ADDR_W-1:0]; end
      OP_RET:    dec_s = I_RET;
      OP_HALT:   dec_s = I_HALT;
      default:   dec_s = I_NOP;
    endcase
  end

  assign decoded_instruction = dec_s;
  assign bus_a_s  = regs_r[a_s];
  assign bus_b_s  = regs_r[b_s];
  assign data_out = bus_a_s;
  assign ram_addr = addr_sel ? pc_r : addr_s;

  // One shared adder serves ADD and SUB; low_s exposes the carry into the MSB.
  assign alu_op_s = alu_op_t'(operation);
  assign sub_s    = (alu_op_s == ALU_SUB);
  assign bop_s    = sub_s ? ~bus_b_s : bus_b_s;
  assign sum_s    = {1'b0, bus_a_s} + {1'b0, bop_s} + {{DATA_W{1'b0}}, sub_s};
  assign low_s    = {1'b0, bus_a_s[DATA_W-2:0]} + {1'b0, bop_s[DATA_W-2:0]} + {{(DATA_W-1){1'b0}}, sub_s};

  // ALU result and overflow flags.
  always_comb begin
    alu_res_s = bus_a_s;
    un_s      = 1'b0;
    sg_s      = 1'b0;
    case (alu_op_s)
      ALU_OR:  alu_res_s = bus_a_s | bus_b_s;
      ALU_AND: alu_res_s = bus_a_s & bus_b_s;
      ALU_XOR: alu_res_s = bus_a_s ^ bus_b_s;
      ALU_ADD, ALU_SUB: begin
        alu_res_s = sum_s[DATA_W-1:0];
        un_s      = sum_s[DATA_W];
        sg_s      = low_s[DATA_W-1] ^ sum_s[DATA_W];
      end
      ALU_SHL: begin
        alu_res_s = {bus_a_s[DATA_W-2:0], 1'b0};
        un_s      = bus_a_s[DATA_W-1];
        sg_s      = bus_a_s[DATA_W-1] ^ bus_a_s[DATA_W-2];
      end
      ALU_SHR: begin
        alu_res_s = {1'b0, bus_a_s[DATA_W-1:1]};
        un_s      = bus_a_s[0];
      end
      ALU_PASS: alu_res_s = bus_a_s;
      default:  alu_res_s = bus_a_s;
    endcase
  end

  assign bus_c_s = c_sel ? alu_res_s : data_in;

  // Register file: synchronous write, asynchronous read (same-cycle read sees the old value).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= '0;
    end else if (write_reg_enable) begin
      regs_r[c_s] <= bus_c_s;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_op           <= (alu_res_s == '0);
      neg_op            <= alu_res_s[DATA_W-1];
      unsigned_overflow <= un_s;
      signed_overflow   <= sg_s;
    end
  end

  // Instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ir_r <= '0;
    else if (ir_enable) ir_r <= data_in;
  end

  ks_return_stack #(.DEPTH(STACK_DEPTH), .ADDR_W(ADDR_W)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pc_enable & stack_push),
    .pop   (pc_enable & stack_pop),
    .din   (pc_r),
    .top   (st_top_s),
    .full  (stack_full),
    .empty (stack_empty),
    .err   (stack_err)
  );

  assign pc_inc_s = pc_r + ADDR_W'(1);

  // Next PC: stack misuse and failed RET fall through, a CALL always takes its target.
  always_comb begin
    if (stack_push && stack_pop)  pc_next_s = pc_inc_s;
    else if (stack_pop)           pc_next_s = stack_empty ? pc_inc_s : st_top_s;
    else if (stack_push || branch) pc_next_s = addr_s;
    else                          pc_next_s = pc_inc_s;
  end

  // Program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         pc_r <= '0;
    else if (pc_enable) pc_r <= pc_next_s;
  end

endmodule
